mul16u_dot_acc: RTL

MUL16U_DOT_ACC -- requirements
Module: mul16u_dot_acc

---
 rtl/mul16u_dot_acc_pkg.sv | 15 +
 rtl/mul16u_dot_acc_core.sv | 14 +
 rtl/mul16u_dot_acc.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mul16u_dot_acc_pkg.sv
// Shared types and widths for the unsigned 16x16 dot-product accumulator.
package mul16u_dot_acc_pkg;

   localparam int OPND_W = 16;
   localparam int PROD_W = 32;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DRAIN,
      HOLD
   } state_t;

endpackage

// File: rtl/mul16u_dot_acc_core.sv
// Combinational 16x16 unsigned multiplier slot. The exact product here is the
// reference behaviour; build flows substitute a library approximate multiplier
// with the same ports, and the accumulator treats O as an opaque product.
module mul16u_core
   import mul16u_dot_acc_pkg::*;
(
   input  logic [OPND_W-1:0] A,
   input  logic [OPND_W-1:0] B,
   output logic [PROD_W-1:0] O
);

   assign O = PROD_W'(A) * PROD_W'(B);

endmodule

// File: rtl/mul16u_dot_acc.sv
// Streaming dot-product accumulator: operand beats are multiplied by the
// mul16u_core slot and summed into a saturating accumulator; one result is
// presented per vector and held until the downstream stage takes it.
module mul16u_dot_acc
   import mul16u_dot_acc_pkg::*;
#(
   parameter int ACC_W     = 40,
   parameter int MAX_TERMS = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPND_W-1:0] in_a,
   input  logic [OPND_W-1:0] in_b,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_TERMS - 1);

   state_t            state;
   logic [CNT_W-1:0]  term_cnt;
   logic              accept;
   logic              closing;
   logic              hold_exit;

   logic [OPND_W-1:0] a_p0;
   logic [OPND_W-1:0] b_p0;
   logic              last_p0;
   logic              vld_p0;

   logic [PROD_W-1:0] prod_c;
   logic [PROD_W-1:0] prod_p1;
   logic              last_p1;
   logic              vld_p1;

   logic [ACC_W-1:0]  acc_p2;
   logic [CNT_W-1:0]  cnt_p2;
   logic              ovf_p2;
   logic [ACC_W:0]    sum_c;

   // Returns {saturated, value}: a carry out of ACC_W bits pins the sum to all-ones.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                              input logic [PROD_W-1:0] prod);
      logic [ACC_W:0] sum;
      sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
      if (sum[ACC_W]) begin
         return {1'b1, {ACC_W{1'b1}}};
      end
      return sum;
   endfunction

   assign accept    = in_valid && in_ready;
   // A vector closes on in_last or when the term budget is used up.
   assign closing   = in_last || (term_cnt == LAST_IDX);
   assign hold_exit = (state == HOLD) && out_ready;

   // Vector control: state, accepted-term counter and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         term_cnt  <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               in_ready <= 1'b1;
               if (accept) begin
                  if (closing) begin
                     state    <= DRAIN;
                     term_cnt <= '0;
                     in_ready <= 1'b0;
                  end else begin
                     state    <= ACCUM;
                     term_cnt <= term_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               in_ready <= 1'b0;
               if (vld_p1 && last_p1) begin
                  state     <= HOLD;
                  out_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---- S1: operand capture ----
   // Registers the accepted operands and whether this beat closes the vector.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
      end else begin
         vld_p0 <= accept;
      end
      if (accept) begin
         a_p0    <= in_a;
         b_p0    <= in_b;
         last_p0 <= closing;
      end
   end

   mul16u_core u_mul (
      .A (a_p0),
      .B (b_p0),
      .O (prod_c)
   );

   // ---- S2: product register ----
   // Captures the multiplier output for the S1 operands.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= vld_p0;
      end
      if (vld_p0) begin
         prod_p1 <= prod_c;
         last_p1 <= last_p0;
      end
   end

   // ---- S3: saturating accumulate ----
   assign sum_c = sat_add(acc_p2, prod_p1);

   // Adds each valid product, counts terms, and clears once the result is taken.
   always_ff @(posedge clk) begin
      if (!rst_n || hold_exit) begin
         acc_p2 <= '0;
         cnt_p2 <= '0;
         ovf_p2 <= 1'b0;
      end else if (vld_p1) begin
         acc_p2 <= sum_c[ACC_W-1:0];
         cnt_p2 <= cnt_p2 + 1'b1;
         ovf_p2 <= ovf_p2 | sum_c[ACC_W];
      end
   end

   assign out_acc   = acc_p2;
   assign out_count = cnt_p2;
   assign out_ovf   = ovf_p2;

endmodule
